// File: rtl/i2s_adc_rx.sv
// I2S master receiver: generates sclk/lrclk, deserializes sdi into PCM words, single-entry stream buffer.
// Define I2S_ADC_RX_LJ_EN for left-justified capture (k=0..DW-1); default is standard I2S (k=1..DW).
module i2s_adc_rx #(
  parameter int DW        = 24,
  parameter int SLOT_BITS = 32,
  parameter int SCLK_DIV  = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic          sclk,
  output logic          lrclk,
  input  logic          sdi,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          dout_chan,
  output logic          overflow
);

  localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BIT_W = $clog2(FRAME);
  localparam int HALF  = SCLK_DIV / 2;
`ifdef I2S_ADC_RX_LJ_EN
  localparam int FIRST_K = 0;
`else
  localparam int FIRST_K = 1;
`endif
  localparam int LAST_K = FIRST_K + DW - 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_next;
  logic             w_in_right;
  logic [BIT_W-1:0] w_slot_k;
  logic             w_capture;
  logic             w_last;
  logic             r_sclk;
  logic             r_lrclk;
  logic [DW-1:0]    r_shift;
  logic             r_done;
  logic             r_done_chan;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_ovf;
  logic [DW-1:0]    r_data;
  logic             r_chan;
  logic             r_ovf;

  // sclk rises when div_cnt becomes HALF and falls when it wraps to 0.
  assign w_sclk_rise = (r_div_cnt == DIV_W'(HALF - 1));
  assign w_sclk_fall = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
  assign w_div_next  = w_sclk_fall ? '0 : r_div_cnt + 1'b1;

  always_comb begin
    w_bit_next = r_bit_cnt;
    if (w_sclk_fall) begin
      if (r_bit_cnt == BIT_W'(FRAME - 1)) begin
        w_bit_next = '0;
      end else begin
        w_bit_next = r_bit_cnt + 1'b1;
      end
    end
  end

  assign w_in_right = (r_bit_cnt >= BIT_W'(SLOT_BITS));
  assign w_slot_k   = w_in_right ? (r_bit_cnt - BIT_W'(SLOT_BITS)) : r_bit_cnt;
  // Wrapping subtraction makes k < FIRST_K land far above DW, so one compare covers both bounds.
  assign w_capture  = w_sclk_rise && ((w_slot_k - BIT_W'(FIRST_K)) < BIT_W'(DW));
  assign w_last     = w_sclk_rise && (w_slot_k == BIT_W'(LAST_K));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_sclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_done_chan <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_next;
      r_bit_cnt   <= w_bit_next;
      r_sclk      <= (w_div_next >= DIV_W'(HALF));
      r_lrclk     <= (w_bit_next >= BIT_W'(SLOT_BITS));
      r_done      <= w_last;
      if (w_capture) begin
        r_shift <= {r_shift[DW-2:0], sdi};
      end
      if (w_last) begin
        r_done_chan <= w_in_right;
      end
    end
  end

  // Buffer control: a completed word is never allowed to stall the serial side.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (r_done) begin
          w_load       = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (r_done && dout_ready) begin
          w_load = 1'b1;
        end else if (r_done) begin
          w_ovf = 1'b1;
        end else if (dout_ready) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_chan  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ovf   <= w_ovf;
      if (w_load) begin
        r_data <= r_shift;
        r_chan <= r_done_chan;
      end
    end
  end

  assign sclk       = r_sclk;
  assign lrclk      = r_lrclk;
  assign dout_valid = (r_state == ST_FULL);
  assign dout_data  = r_data;
  assign dout_chan  = r_chan;
  assign overflow   = r_ovf;

endmodule
